// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// stopwatch_pkg : shared state encoding and constants for the stopwatch control
// Rev 1.0
// ---------------------------------------------------------------------------
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LAP  = 2'd2,
    STOP = 2'd3
  } state_t;

  localparam logic [15:0] BCD_MAX                 = 16'h9999;
  localparam int          DIV_COUNT_DEFAULT       = 50000;
  localparam int          DEBOUNCE_CYCLES_DEFAULT = 500000;

endpackage : stopwatch_pkg
`default_nettype wire

// File: rtl/stopwatch_ctrl_key_debounce.sv
`default_nettype none
// ---------------------------------------------------------------------------
// key_debounce : synchroniser, stable-count debouncer and press pulse for one
//                active-low push-button.  Rev 1.0
// ---------------------------------------------------------------------------
module key_debounce
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic press
);

  localparam int                 C_CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(DEBOUNCE_CYCLES - 1);

  logic               r_sync1;
  logic               r_sync2;
  logic               r_level;
  logic [C_CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_level <= 1'b1;
      r_cnt   <= '0;
      press   <= 1'b0;
    end else begin
      r_sync1 <= key_n;
      r_sync2 <= r_sync1;
      press   <= 1'b0;
      // Any sample equal to the accepted level restarts the stability count
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == C_CNT_LAST) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
        press   <= ~r_sync2;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule : key_debounce
`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// stopwatch_ctrl : key handling, 1 kHz tick divider, lap hold and overflow FSM
//                  for the four-digit BCD stopwatch.  Rev 1.0
// ---------------------------------------------------------------------------
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DIV_COUNT       = DIV_COUNT_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter bit WRAP            = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        key_ss_n,
  input  logic        key_lr_n,
  input  logic [15:0] count_in,
  output logic        tick_en,
  output logic        cnt_clear,
  output logic [15:0] disp_digits,
  output logic        running,
  output logic        lap_active,
  output logic        overflow
);

  localparam int                 C_DIV_W    = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;
  localparam logic [C_DIV_W-1:0] C_DIV_LAST = C_DIV_W'(DIV_COUNT - 1);

  logic w_ss;
  logic w_lr;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_ss (
    .clk   (clk),
    .reset (reset),
    .key_n (key_ss_n),
    .press (w_ss)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_lr (
    .clk   (clk),
    .reset (reset),
    .key_n (key_lr_n),
    .press (w_lr)
  );

  state_t             r_state;
  logic [C_DIV_W-1:0] r_div;
  logic [15:0]        r_hold;

  state_t             w_state_nxt;
  logic [C_DIV_W-1:0] w_div_nxt;
  logic [15:0]        w_hold_nxt;
  logic               w_ovf_nxt;
  logic               w_clear_nxt;
  logic               w_active;
  logic               w_active_nxt;
  logic               w_tick_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_div_nxt   = r_div;
    w_hold_nxt  = r_hold;
    w_ovf_nxt   = overflow;
    w_clear_nxt = 1'b0;
    w_active    = (r_state == RUN) || (r_state == LAP);

    if (w_active) begin
      w_div_nxt = (r_div == C_DIV_LAST) ? '0 : r_div + 1'b1;
    end

    // Start/stop is tested first so it wins over a same-cycle lap/reset
    case (r_state)
      IDLE: begin
        if (w_ss) begin
          w_state_nxt = RUN;
        end else if (w_lr) begin
          w_clear_nxt = 1'b1;
        end
      end
      RUN: begin
        if (w_ss) begin
          w_state_nxt = STOP;
        end else if (w_lr) begin
          w_state_nxt = LAP;
          w_hold_nxt  = count_in;
        end
      end
      LAP: begin
        if (w_ss) begin
          w_state_nxt = STOP;
        end else if (w_lr) begin
          w_state_nxt = RUN;
        end
      end
      STOP: begin
        if (w_ss) begin
          if (!overflow) begin
            w_state_nxt = RUN;
          end
        end else if (w_lr) begin
          w_state_nxt = IDLE;
          w_clear_nxt = 1'b1;
          w_ovf_nxt   = 1'b0;
          w_div_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_div_nxt   = '0;
      end
    endcase

    if (w_active && (r_div == C_DIV_LAST) && (count_in == BCD_MAX)) begin
      w_ovf_nxt = 1'b1;
      if (!WRAP) begin
        w_state_nxt = STOP;
      end
    end

    // tick_en is registered one cycle ahead; count_in only moves after a
    // tick, so its value now is the value it will hold in the tick cycle.
    w_active_nxt = (w_state_nxt == RUN) || (w_state_nxt == LAP);
    w_tick_nxt   = w_active_nxt && (w_div_nxt == C_DIV_LAST) &&
                   !(!WRAP && (count_in == BCD_MAX));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_div      <= '0;
      r_hold     <= '0;
      overflow   <= 1'b0;
      tick_en    <= 1'b0;
      cnt_clear  <= 1'b1;
      running    <= 1'b0;
      lap_active <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_div      <= w_div_nxt;
      r_hold     <= w_hold_nxt;
      overflow   <= w_ovf_nxt;
      tick_en    <= w_tick_nxt;
      cnt_clear  <= w_clear_nxt;
      running    <= w_active_nxt;
      lap_active <= (w_state_nxt == LAP);
    end
  end

  assign disp_digits = (r_state == LAP) ? r_hold : count_in;

endmodule : stopwatch_ctrl
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_stopwatch_ctrl : directed self-checking bench, WRAP=0 and WRAP=1 side by side
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_stopwatch_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        key_ss_n = 1'b1;
  logic        key_lr_n = 1'b1;
  logic [15:0] count_in = 16'h0000;

  logic        tick_en,   tick_en_w;
  logic        cnt_clear, cnt_clear_w;
  logic [15:0] disp,      disp_w;
  logic        running,   running_w;
  logic        lap,       lap_w;
  logic        ovf,       ovf_w;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  stopwatch_ctrl #(.DIV_COUNT(4), .DEBOUNCE_CYCLES(3), .WRAP(1'b0)) dut (
    .clk(clk), .reset(reset), .key_ss_n(key_ss_n), .key_lr_n(key_lr_n),
    .count_in(count_in), .tick_en(tick_en), .cnt_clear(cnt_clear),
    .disp_digits(disp), .running(running), .lap_active(lap), .overflow(ovf)
  );

  stopwatch_ctrl #(.DIV_COUNT(4), .DEBOUNCE_CYCLES(3), .WRAP(1'b1)) dut_w (
    .clk(clk), .reset(reset), .key_ss_n(key_ss_n), .key_lr_n(key_lr_n),
    .count_in(count_in), .tick_en(tick_en_w), .cnt_clear(cnt_clear_w),
    .disp_digits(disp_w), .running(running_w), .lap_active(lap_w), .overflow(ovf_w)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // mask bit0 = start/stop, bit1 = lap/reset; returns right after the FSM reacts
  task automatic do_press(input logic [1:0] mask);
    step(6);
    if (mask[0]) key_ss_n = 1'b0;
    if (mask[1]) key_lr_n = 1'b0;
    step(6);
    key_ss_n = 1'b1;
    key_lr_n = 1'b1;
  endtask

  initial begin
    bit found;
    int at;

    // 1. reset
    step(3);
    chk("rst_clear", cnt_clear, 1'b1);
    chk("rst_tick", tick_en, 1'b0);
    chk("rst_running", running, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_lap", lap, 1'b0);
    reset = 1'b0;
    step(1);
    chk("clear_release", cnt_clear, 1'b0);

    // 2. glitch rejection, then a held start press
    key_ss_n = 1'b0;
    step(2);
    key_ss_n = 1'b1;
    step(8);
    chk("glitch_running", running, 1'b0);
    chk("glitch_running_w", running_w, 1'b0);
    key_ss_n = 1'b0;
    step(5);
    chk("start_early", running, 1'b0);
    step(1);
    chk("start_latency", running, 1'b1);
    chk("start_latency_w", running_w, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      step(1);
      if (i == 4) key_ss_n = 1'b1;
      chk($sformatf("tick_phase_%0d", i), tick_en, (i % 4) == 3);
    end
    step(8);
    chk("single_event", running, 1'b1);

    // 3. lap hold
    count_in = 16'h0123;
    do_press(2'b10);
    chk("lap_on", lap, 1'b1);
    chk("lap_running", running, 1'b1);
    chk("lap_disp", disp, 16'h0123);
    count_in = 16'h0130;
    step(1);
    chk("lap_hold", disp, 16'h0123);
    do_press(2'b10);
    chk("lap_off", lap, 1'b0);
    chk("lap_live", disp, 16'h0130);
    count_in = 16'h0131;
    step(1);
    chk("lap_track", disp, 16'h0131);

    // 4/5. overflow: align to a tick, then present 9999 for the next one
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      step(1);
      if (tick_en_w) found = 1'b1;
    end
    chk("tick_seen", found, 1'b1);
    step(1);
    count_in = 16'h9999;
    found = 1'b0;
    at = 0;
    for (int i = 1; i <= 4 && !found; i++) begin
      step(1);
      if (tick_en_w) begin
        found = 1'b1;
        at = i;
      end
    end
    chk("ovf_tick_w1", found, 1'b1);
    chk("ovf_tick_pos", at, 3);
    chk("ovf_tick_w0", tick_en, 1'b0);
    chk("ovf_pre_flag", ovf, 1'b0);
    step(1);
    chk("ovf_w0_flag", ovf, 1'b1);
    chk("ovf_w0_running", running, 1'b0);
    chk("ovf_w0_disp", disp, 16'h9999);
    chk("ovf_w1_flag", ovf_w, 1'b1);
    chk("ovf_w1_running", running_w, 1'b1);
    do_press(2'b01);
    chk("ovf_ss_ignored", running, 1'b0);
    chk("ovf_sticky", ovf, 1'b1);
    chk("ovf_w1_stop", running_w, 1'b0);
    chk("ovf_w1_sticky", ovf_w, 1'b1);

    // 6. clear from STOP
    do_press(2'b10);
    chk("stop_clear", cnt_clear, 1'b1);
    chk("stop_clear_ovf", ovf, 1'b0);
    chk("stop_idle", running, 1'b0);
    chk("stop_clear_w", cnt_clear_w, 1'b1);
    chk("stop_clear_ovf_w", ovf_w, 1'b0);
    step(1);
    chk("clear_pulse", cnt_clear, 1'b0);

    // 6. simultaneous keys in RUN
    count_in = 16'h0456;
    do_press(2'b01);
    chk("restart", running, 1'b1);
    do_press(2'b10);
    chk("lap2_disp", disp, 16'h0456);
    do_press(2'b10);
    chk("lap2_off", lap, 1'b0);
    count_in = 16'h0777;
    do_press(2'b11);
    chk("both_running", running, 1'b0);
    chk("both_lap", lap, 1'b0);
    chk("both_hold", dut.r_hold, 16'h0456);
    chk("both_running_w", running_w, 1'b0);
    chk("both_disp", disp, 16'h0777);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_stopwatch_ctrl
`default_nettype wire

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Control FSM for the four-digit BCD stopwatch chain (ms, cs, ds, s digits). Debounces the two board push-buttons, generates the 1 kHz count-enable tick and the counter clear, and handles lap (display hold) and overflow at 9.999 s. Sits between KEY inputs, the BCD counter chain (all digits on clk) and the seven-segment decoders.

Parameters:
DIV_COUNT, 50000, clk cycles per count tick (50 MHz -> 1 kHz)
DEBOUNCE_CYCLES, 500000, cycles a raw key level must be stable to be accepted (10 ms)
WRAP, 0, 0: saturate and stop at 9.999; 1: wrap to 0.000 and keep running

Ports:
clk  in  1  system clock, 50 MHz
reset  in  1  synchronous, active-high reset
key_ss_n  in  1  raw start/stop button, active-low, asynchronous
key_lr_n  in  1  raw lap/reset button, active-low, asynchronous
count_in  in  16  live BCD count {s, ds, cs, ms}, 4 bits per digit
tick_en  out  1  one-cycle count enable to the ms digit
cnt_clear  out  1  active-high clear to all digits (top level inverts for active-low clear)
disp_digits  out  16  BCD value to display: live count or held lap value
running  out  1  high in RUN and LAP
lap_active  out  1  high in LAP
overflow  out  1  sticky; set when 9.999 is reached, cleared only on return to IDLE

Behaviour:
- Reset (while reset=1 at a clk edge): state=IDLE; divider=0; hold_reg=0; overflow=0; tick_en=0; cnt_clear=1. cnt_clear deasserts on the first edge with reset=0.
- Key path (per key): 2-flop synchroniser; debounced level updates only after DEBOUNCE_CYCLES consecutive equal samples; a press event is a one-cycle pulse on the debounced 1->0 transition. Release generates nothing. Holding a key generates one event.
- Latency: raw edge -> event = 2 + DEBOUNCE_CYCLES cycles; event -> state/outputs change on the next edge.
- Divider: counts 0..DIV_COUNT-1 only in RUN/LAP; tick_en=1 for exactly the cycle the divider is at DIV_COUNT-1. Frozen (not cleared) in STOP, so resume keeps phase. Cleared to 0 on entering IDLE.
- FSM (ss = start/stop event, lr = lap/reset event):
  IDLE: ss -> RUN. lr -> IDLE with one-cycle cnt_clear.
  RUN: ss -> STOP. lr -> LAP, hold_reg <= count_in in the same edge.
  LAP: ss -> STOP (hold released, display live). lr -> RUN (hold released).
  STOP: ss -> RUN, unless overflow=1 (ignored). lr -> IDLE with one-cycle cnt_clear, overflow<=0, divider<=0.
- Simultaneous ss and lr in one cycle: ss wins, lr is dropped.
- disp_digits = hold_reg in LAP, else count_in (combinational mux).
- Overflow, at the tick cycle in RUN/LAP with count_in==16'h9999:
  WRAP=0: tick_en suppressed; overflow<=1; state -> STOP; display live.
  WRAP=1: tick_en asserted (chain wraps to 0000); overflow<=1; state unchanged.
- Reset asserted mid-operation: takes effect at the next edge regardless of state or pending events; any in-progress debounce count is discarded.
- No combinational path from the key inputs to any output. All outputs except disp_digits are registered.

Decomposition:
- Package stopwatch_pkg: state enum (IDLE, RUN, LAP, STOP), BCD_MAX = 16'h9999, default DIV_COUNT and DEBOUNCE_CYCLES constants.
- Sub-module key_debounce (synchroniser + stable-count debouncer + press pulse, parameter DEBOUNCE_CYCLES), instantiated twice. The divider and FSM stay in the top of the block.

Test Plan:
All scenarios use DIV_COUNT=4 and DEBOUNCE_CYCLES=3.
1. Reset: hold reset 3 cycles -> cnt_clear=1, tick_en=0, running=0, overflow=0; cnt_clear=0 one cycle after reset drops.
2. Start and glitch rejection: 2-cycle low glitch on key_ss_n -> no state change. Then hold low 10 cycles -> running=1 at 2+3+1 cycles after the edge; tick_en pulses every 4th cycle; exactly one event while held.
3. Lap: in RUN with count_in=16'h0123, press lr -> lap_active=1, disp_digits=16'h0123 while count_in advances to 16'h0130. Press lr again -> lap_active=0, disp_digits tracks count_in.
4. Overflow, WRAP=0: RUN with count_in=16'h9999 at the tick cycle -> tick_en stays 0, overflow=1, running=0. A later ss press is ignored.
5. Overflow, WRAP=1: same stimulus -> tick_en=1, overflow=1, running stays 1.
6. Stop/clear and simultaneous keys: in STOP press lr -> one-cycle cnt_clear, state IDLE, overflow=0. In RUN, ss and lr events in the same cycle -> STOP, lap_active=0, hold_reg unchanged.
